// File: rtl/serpent_xts_sector_ctrl.sv
// serpent_xts_sector_ctrl
// Sequences XTS encryption/decryption of one sector through a single shared
// Serpent core. The core first encrypts the sector number with key2 to form
// the tweak T, then processes every data block with key1 as
//    out = E/D_key1(in ^ T) ^ T
// and T is multiplied by alpha in GF(2^128) after each output block.
//
// Ports:
//   i_clk, i_rstn              clock, asynchronous active-low reset
//   i_key_valid, i_key         {key1, key2}; i_key_valid must stay high for the
//                              whole sector, dropping it abandons the sector
//   i_start, i_decrypt,        sector start pulse (IDLE only), direction and
//   i_sector                   sector number, all sampled with i_start
//   o_busy                     high outside IDLE
//   i_blk_valid/o_blk_ready    input block stream, i_blk
//   o_blk_valid/i_blk_ready    output block stream, o_blk
//   o_sector_done, o_abort     one-cycle completion / abandonment pulses
//   o_core_*, i_core_*         request/response to the shared cipher core
//
// Handshakes: a transfer happens on a rising clock edge where valid and ready
// are both high. o_blk and o_blk_valid hold until accepted. The core request
// o_core_enable holds until i_core_valid is seen and then drops for at least
// one cycle before the next request; i_core_valid is ignored while the
// request is low.
module serpent_xts_sector_ctrl #(
   parameter int BLOCKS_PER_SECTOR = 32,
   parameter int CNT_W             = 16
) (
   input  logic         i_clk,
   input  logic         i_rstn,
   input  logic         i_key_valid,
   input  logic [511:0] i_key,
   input  logic         i_start,
   input  logic         i_decrypt,
   input  logic [63:0]  i_sector,
   output logic         o_busy,
   input  logic         i_blk_valid,
   output logic         o_blk_ready,
   input  logic [127:0] i_blk,
   output logic         o_blk_valid,
   input  logic         i_blk_ready,
   output logic [127:0] o_blk,
   output logic         o_sector_done,
   output logic         o_abort,
   output logic         o_core_enable,
   output logic         o_core_decrypt,
   output logic [255:0] o_core_key,
   output logic [127:0] o_core_data,
   input  logic [127:0] i_core_data,
   input  logic         i_core_valid
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_TWEAK,
      S_GET_BLK,
      S_CIPHER,
      S_EMIT,
      S_DONE
   } state_t;

   localparam logic [CNT_W-1:0] LAST_BLK = CNT_W'(BLOCKS_PER_SECTOR - 1);

   state_t         r_state;
   state_t         w_next;
   logic [255:0]   r_key1;
   logic [255:0]   r_key2;
   logic           r_dec;
   logic [127:0]   r_t;
   logic [127:0]   r_core_data;
   logic [127:0]   r_blk;
   logic [CNT_W-1:0] r_cnt;
   logic           r_abort;

   logic           w_abandon;
   logic           w_last;
   logic [127:0]   w_t_next;

   // Losing the key in any active state abandons the sector.
   assign w_abandon = (r_state != S_IDLE) && !i_key_valid;
   assign w_last    = (r_cnt == LAST_BLK);
   // Multiply by alpha: shift left, fold the carried-out bit back with x^7+x^2+x+1.
   assign w_t_next  = {r_t[126:0], 1'b0} ^ (r_t[127] ? 128'h87 : 128'h0);

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) r_state <= S_IDLE;
      else         r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      if (w_abandon) begin
         w_next = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE:    if (i_start && i_key_valid) w_next = S_TWEAK;
            S_TWEAK:   if (i_core_valid)           w_next = S_GET_BLK;
            S_GET_BLK: if (i_blk_valid)            w_next = S_CIPHER;
            S_CIPHER:  if (i_core_valid)           w_next = S_EMIT;
            S_EMIT:    if (i_blk_ready)            w_next = w_last ? S_DONE : S_GET_BLK;
            S_DONE:                                w_next = S_IDLE;
            default:                               w_next = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         r_key1      <= '0;
         r_key2      <= '0;
         r_dec       <= 1'b0;
         r_t         <= '0;
         r_core_data <= '0;
         r_blk       <= '0;
         r_cnt       <= '0;
         r_abort     <= 1'b0;
      end else begin
         r_abort <= 1'b0;
         if (w_abandon) begin
            r_abort <= 1'b1;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (i_start && i_key_valid) begin
                     r_key1      <= i_key[511:256];
                     r_key2      <= i_key[255:0];
                     r_dec       <= i_decrypt;
                     r_core_data <= {64'h0, i_sector};
                     r_cnt       <= '0;
                  end
               end
               S_TWEAK:   if (i_core_valid) r_t <= i_core_data;
               S_GET_BLK: if (i_blk_valid)  r_core_data <= i_blk ^ r_t;
               S_CIPHER:  if (i_core_valid) r_blk <= i_core_data ^ r_t;
               S_EMIT: begin
                  if (i_blk_ready) begin
                     r_t <= w_t_next;
                     if (!w_last) r_cnt <= r_cnt + CNT_W'(1);
                  end
               end
               default: ;
            endcase
         end
      end
   end

   // Control outputs decode straight from the state register, so they fall in
   // the same edge that leaves the state (including an abandon to IDLE).
   assign o_busy         = (r_state != S_IDLE);
   assign o_blk_ready    = (r_state == S_GET_BLK);
   assign o_blk_valid    = (r_state == S_EMIT);
   assign o_blk          = r_blk;
   assign o_sector_done  = (r_state == S_DONE);
   assign o_abort        = r_abort;
   assign o_core_enable  = (r_state == S_TWEAK) || (r_state == S_CIPHER);
   assign o_core_decrypt = (r_state == S_CIPHER) && r_dec;
   assign o_core_key     = (r_state == S_TWEAK)  ? r_key2 :
                           (r_state == S_CIPHER) ? r_key1 : 256'h0;
   assign o_core_data    = r_core_data;

endmodule

// File: tb/tb_serpent_xts_sector_ctrl.sv
module tb_serpent_xts_sector_ctrl;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  // shared stimulus
  logic         start = 1'b0;
  logic         dec = 1'b0;
  logic [511:0] key = '0;
  logic [63:0]  sector = '0;
  logic         blk_v = 1'b0;
  logic [127:0] blk = '0;
  logic         blk_rdy = 1'b0;
  logic         force_cv = 1'b0;
  logic [1:0]   kv = 2'b00;

  // per-DUT outputs: index 0 = 2-block sector, index 1 = 32-block sector
  logic [1:0]          busy_a, brdy_a, bval_a, done_a, abort_a, cen_a, cdec_a, cv_a;
  logic [1:0][127:0]   blk_a, cdata_a, cdin_a;
  logic [1:0][255:0]   ckey_a;

  serpent_xts_sector_ctrl #(.BLOCKS_PER_SECTOR(2), .CNT_W(16)) u_dut_a (
    .i_clk(clk), .i_rstn(rstn), .i_key_valid(kv[0]), .i_key(key),
    .i_start(start), .i_decrypt(dec), .i_sector(sector), .o_busy(busy_a[0]),
    .i_blk_valid(blk_v), .o_blk_ready(brdy_a[0]), .i_blk(blk),
    .o_blk_valid(bval_a[0]), .i_blk_ready(blk_rdy), .o_blk(blk_a[0]),
    .o_sector_done(done_a[0]), .o_abort(abort_a[0]),
    .o_core_enable(cen_a[0]), .o_core_decrypt(cdec_a[0]), .o_core_key(ckey_a[0]),
    .o_core_data(cdata_a[0]), .i_core_data(cdin_a[0]), .i_core_valid(cv_a[0]));

  serpent_xts_sector_ctrl #(.BLOCKS_PER_SECTOR(32), .CNT_W(16)) u_dut_b (
    .i_clk(clk), .i_rstn(rstn), .i_key_valid(kv[1]), .i_key(key),
    .i_start(start), .i_decrypt(dec), .i_sector(sector), .o_busy(busy_a[1]),
    .i_blk_valid(blk_v), .o_blk_ready(brdy_a[1]), .i_blk(blk),
    .o_blk_valid(bval_a[1]), .i_blk_ready(blk_rdy), .o_blk(blk_a[1]),
    .o_sector_done(done_a[1]), .o_abort(abort_a[1]),
    .o_core_enable(cen_a[1]), .o_core_decrypt(cdec_a[1]), .o_core_key(ckey_a[1]),
    .o_core_data(cdata_a[1]), .i_core_data(cdin_a[1]), .i_core_valid(cv_a[1]));

  // core model: result = data ^ key[127:0], valid after 3 cycles of enable
  logic [1:0][1:0] cm_cnt;
  logic [1:0]      cm_valid;
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cm_cnt   <= '0;
      cm_valid <= '0;
      cdin_a   <= '0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (cen_a[k] && !cm_valid[k]) begin
          if (cm_cnt[k] == 2'd2) begin
            cm_valid[k] <= 1'b1;
            cdin_a[k]   <= cdata_a[k] ^ ckey_a[k][127:0];
            cm_cnt[k]   <= 2'd0;
          end else begin
            cm_cnt[k] <= cm_cnt[k] + 2'd1;
          end
        end else begin
          cm_valid[k] <= 1'b0;
          cm_cnt[k]   <= 2'd0;
        end
      end
    end
  end
  assign cv_a = cm_valid | {2{force_cv}};

  // observed DUT selection
  logic sel = 1'b0;
  logic         w_busy, w_brdy, w_bval, w_done, w_abort, w_cen, w_cdec;
  logic [127:0] w_blk, w_cdata;
  logic [255:0] w_ckey;
  assign w_busy  = busy_a[sel];
  assign w_brdy  = brdy_a[sel];
  assign w_bval  = bval_a[sel];
  assign w_done  = done_a[sel];
  assign w_abort = abort_a[sel];
  assign w_cen   = cen_a[sel];
  assign w_cdec  = cdec_a[sel];
  assign w_blk   = blk_a[sel];
  assign w_cdata = cdata_a[sel];
  assign w_ckey  = ckey_a[sel];

  int hs_cnt = 0;
  int done_cnt = 0;
  int abort_cnt = 0;
  always @(posedge clk) begin
    if (w_bval && blk_rdy) hs_cnt <= hs_cnt + 1;
    if (w_done)            done_cnt <= done_cnt + 1;
    if (w_abort)           abort_cnt <= abort_cnt + 1;
  end

  int n_total = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] mul_alpha(input logic [127:0] t);
    return {t[126:0], 1'b0} ^ (t[127] ? 128'h87 : 128'h0);
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_ready(input string tag);
    int i;
    for (i = 0; i < 30 && !w_brdy; i++) tick(1);
    if (!w_brdy) chk({tag, "_ready_tmo"}, 128'd0, 128'd1);
  endtask

  task automatic wait_valid(input string tag);
    int i;
    for (i = 0; i < 30 && !w_bval; i++) tick(1);
    if (!w_bval) chk({tag, "_valid_tmo"}, 128'd0, 128'd1);
  endtask

  // pulse i_start; returns at the negedge after the accepting edge (TWEAK)
  task automatic start_sector(input logic [63:0] s, input logic d);
    sector = s;
    dec    = d;
    start  = 1'b1;
    tick(1);
    start  = 1'b0;
  endtask

  task automatic check_tweak(input string tag, input logic [127:0] exp_cd,
                             input logic [127:0] exp_k2);
    chk({tag, "_busy"}, 128'(w_busy), 128'd1);
    chk({tag, "_cen"},  128'(w_cen), 128'd1);
    chk({tag, "_cdec"}, 128'(w_cdec), 128'd0);
    chk({tag, "_cd"},   w_cdata, exp_cd);
    chk({tag, "_key"},  w_ckey[127:0], exp_k2);
  endtask

  // one data block: send b, check the core request, check the output, hold
  // i_blk_ready low for 'hold' cycles, then accept the output
  task automatic run_block(input string tag, input logic [127:0] b,
                           input logic [127:0] exp_cd, input logic [127:0] exp_out,
                           input logic d, input int hold);
    wait_ready(tag);
    blk_v = 1'b1;
    blk   = b;
    tick(1);
    blk_v = 1'b0;
    chk({tag, "_cen"},  128'(w_cen), 128'd1);
    chk({tag, "_cd"},   w_cdata, exp_cd);
    chk({tag, "_key"},  w_ckey[127:0], 128'h0F);
    chk({tag, "_cdec"}, 128'(w_cdec), 128'(d));
    wait_valid(tag);
    chk({tag, "_out"}, w_blk, exp_out);
    for (int i = 0; i < hold; i++) begin
      tick(1);
      chk($sformatf("%s_hold%0d_out", tag, i), w_blk, exp_out);
      chk($sformatf("%s_hold%0d_val", tag, i), 128'(w_bval), 128'd1);
      chk($sformatf("%s_hold%0d_cen", tag, i), 128'(w_cen), 128'd0);
      chk($sformatf("%s_hold%0d_rdy", tag, i), 128'(w_brdy), 128'd0);
    end
    blk_rdy = 1'b1;
    tick(1);
    blk_rdy = 1'b0;
    chk({tag, "_val_low"}, 128'(w_bval), 128'd0);
  endtask

  task automatic check_done(input string tag, input int done_base);
    chk({tag, "_done"}, 128'(w_done), 128'd1);
    tick(1);
    chk({tag, "_done_low"}, 128'(w_done), 128'd0);
    chk({tag, "_idle"}, 128'(w_busy), 128'd0);
    chk({tag, "_done_cnt"}, 128'(done_cnt - done_base), 128'd1);
  endtask

  initial begin
    int dbase, abase, hbase;
    logic [127:0] t, b;

    // reset state
    tick(2);
    chk("rst_busy", 128'(w_busy), 128'd0);
    chk("rst_cen",  128'(w_cen), 128'd0);
    chk("rst_bval", 128'(w_bval), 128'd0);
    chk("rst_brdy", 128'(w_brdy), 128'd0);
    chk("rst_done", 128'(w_done), 128'd0);
    chk("rst_abort", 128'(w_abort), 128'd0);
    chk("rst_blk",  w_blk, 128'd0);
    chk("rst_cd",   w_cdata, 128'd0);
    chk("rst_key",  w_ckey[127:0], 128'd0);
    rstn = 1'b1;
    tick(1);

    // 1: two-block decrypt sector, T0 = A5, T1 = 14A
    kv = 2'b01;
    key = {256'h0F, 256'hA0};
    dbase = done_cnt;
    start_sector(64'h5, 1'b1);
    check_tweak("t1_tw", 128'h5, 128'hA0);
    key    = {$urandom, $urandom, $urandom, $urandom, 384'h0};
    dec    = 1'b0;
    sector = 64'hFFFF;
    run_block("t1_b0", 128'h1, 128'hA4, 128'h0E, 1'b1, 0);
    run_block("t1_b1", 128'h0, 128'h14A, 128'h0F, 1'b1, 0);
    check_done("t1", dbase);

    // 2+3: T0 with bit 127 set, backpressure on block 0
    key = {256'h0F, 128'h0, 128'h8000_0000_0000_0000_0000_0000_0000_0000};
    dbase = done_cnt;
    start_sector(64'h1, 1'b0);
    check_tweak("t2_tw", 128'h1, 128'h8000_0000_0000_0000_0000_0000_0000_0000);
    run_block("t2_b0", 128'h3, 128'h8000_0000_0000_0000_0000_0000_0000_0002, 128'h0C, 1'b0, 10);
    run_block("t2_b1", 128'h0, 128'h85, 128'h0F, 1'b0, 0);
    check_done("t2", dbase);

    // 4: key dropped during CIPHER
    key = {256'h0F, 256'hA0};
    abase = abort_cnt;
    dbase = done_cnt;
    start_sector(64'h2, 1'b1);
    wait_ready("t4");
    blk_v = 1'b1;
    blk   = 128'h1;
    tick(1);
    blk_v = 1'b0;
    chk("t4_cen", 128'(w_cen), 128'd1);
    tick(1);
    kv = 2'b00;
    tick(1);
    chk("t4_abort", 128'(w_abort), 128'd1);
    chk("t4_busy",  128'(w_busy), 128'd0);
    chk("t4_cen_low", 128'(w_cen), 128'd0);
    chk("t4_brdy",  128'(w_brdy), 128'd0);
    chk("t4_bval",  128'(w_bval), 128'd0);
    tick(1);
    chk("t4_abort_low", 128'(w_abort), 128'd0);
    force_cv = 1'b1;
    tick(1);
    force_cv = 1'b0;
    tick(1);
    chk("t4_late_busy", 128'(w_busy), 128'd0);
    chk("t4_late_bval", 128'(w_bval), 128'd0);
    chk("t4_late_blk",  w_blk, 128'h0F);
    chk("t4_abort_cnt", 128'(abort_cnt - abase), 128'd1);
    chk("t4_done_cnt",  128'(done_cnt - dbase), 128'd0);
    kv = 2'b01;
    dbase = done_cnt;
    start_sector(64'h7, 1'b0);
    check_tweak("t4r_tw", 128'h7, 128'hA0);
    run_block("t4r_b0", 128'h5, 128'hA2, 128'h0A, 1'b0, 0);
    run_block("t4r_b1", 128'hF0, 128'h1BE, 128'hFF, 1'b0, 0);
    check_done("t4r", dbase);

    // 5: start while busy, start without key
    dbase = done_cnt;
    start_sector(64'h3, 1'b1);
    wait_ready("t5");
    start  = 1'b1;
    sector = 64'h55;
    tick(1);
    start  = 1'b0;
    chk("t5_busy", 128'(w_busy), 128'd1);
    chk("t5_brdy", 128'(w_brdy), 128'd1);
    chk("t5_cen",  128'(w_cen), 128'd0);
    run_block("t5_b0", 128'h10, 128'hB3, 128'h1F, 1'b1, 0);
    run_block("t5_b1", 128'h0, 128'h146, 128'h0F, 1'b1, 0);
    check_done("t5", dbase);
    kv = 2'b00;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    chk("t5_nokey_busy", 128'(w_busy), 128'd0);
    chk("t5_nokey_cen",  128'(w_cen), 128'd0);
    tick(1);
    chk("t5_nokey_busy2", 128'(w_busy), 128'd0);
    chk("t5_b_never", 128'(busy_a[1]), 128'd0);

    // 6: reset during TWEAK, then a full 32-block sector
    sel = 1'b1;
    kv  = 2'b10;
    start_sector(64'h9, 1'b0);
    chk("t6_tw_busy", 128'(w_busy), 128'd1);
    tick(1);
    rstn = 1'b0;
    #1;
    chk("t6_rst_busy", 128'(w_busy), 128'd0);
    chk("t6_rst_cen",  128'(w_cen), 128'd0);
    chk("t6_rst_cd",   w_cdata, 128'd0);
    chk("t6_rst_keyh", w_ckey[255:128], 128'd0);
    chk("t6_rst_keyl", w_ckey[127:0], 128'd0);
    chk("t6_rst_blk_a", blk_a[0], 128'd0);
    tick(2);
    rstn = 1'b1;
    tick(1);
    dbase = done_cnt;
    abase = abort_cnt;
    hbase = hs_cnt;
    start_sector(64'h9, 1'b0);
    check_tweak("t6_tw", 128'h9, 128'hA0);
    t = 128'hA9;
    for (int i = 0; i < 32; i++) begin
      b = 128'(i * 3 + 1);
      run_block($sformatf("t6_b%0d", i), b, b ^ t, b ^ 128'h0F, 1'b0, 0);
      t = mul_alpha(t);
    end
    check_done("t6", dbase);
    chk("t6_hs_cnt", 128'(hs_cnt - hbase), 128'd32);
    chk("t6_abort_cnt", 128'(abort_cnt - abase), 128'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/serpent_xts_sector_ctrl.md
Name: serpent_xts_sector_ctrl

Overview:
Sequences XTS decryption or encryption of one whole sector through a single shared Serpent block-cipher core. The same core computes the tweak with key2, then processes each data block with key1. Between blocks the block updates the tweak by GF(2^128) multiplication by alpha. It sits between the sector-level storage datapath (block streams in and out) and one cipher-core instance.

Parameters:
BLOCKS_PER_SECTOR, 32, number of 128-bit blocks per sector (32 = 512 B); legal range 1..65535.
CNT_W, 16, width of the block counter.

Ports:
i_clk  in  1  clock
i_rstn  in  1  asynchronous active-low reset
i_key_valid  in  1  i_key is valid; must stay high for the whole sector
i_key  in  512  [511:256] = key1 (data key), [255:0] = key2 (tweak key)
i_start  in  1  start-sector pulse, accepted only in IDLE with i_key_valid = 1
i_decrypt  in  1  direction: 1 = decrypt, 0 = encrypt; sampled with i_start
i_sector  in  64  sector number; sampled with i_start
o_busy  out  1  high in every state except IDLE
i_blk_valid  in  1  input block valid
o_blk_ready  out  1  controller accepts an input block
i_blk  in  128  input block
o_blk_valid  out  1  output block valid
i_blk_ready  in  1  sink accepts the output block
o_blk  out  128  output block
o_sector_done  out  1  one-cycle pulse after the last block is accepted
o_abort  out  1  one-cycle pulse when a sector is abandoned
o_core_enable  out  1  core request; held high until i_core_valid
o_core_decrypt  out  1  core direction
o_core_key  out  256  core key
o_core_data  out  128  core input block
i_core_data  in  128  core result
i_core_valid  in  1  core result valid (sampled only while o_core_enable = 1)

Behaviour:
- Reset values: all outputs 0, state IDLE, internal tweak T = 0, counter = 0, latched keys = 0.
- States: IDLE, TWEAK, GET_BLK, CIPHER, EMIT, DONE.
- IDLE → TWEAK when i_start and i_key_valid are both high. On that edge: latch key1, key2, i_decrypt, and core input {64'h0, i_sector}; clear the counter. i_start in any other state is ignored.
- TWEAK:
  - o_core_enable = 1, o_core_decrypt = 0 (the tweak is always an encryption), o_core_key = key2.
  - On i_core_valid: T ← i_core_data, o_core_enable ← 0, go to GET_BLK.
- GET_BLK:
  - o_blk_ready = 1, o_core_enable = 0.
  - On i_blk_valid: o_core_data ← i_blk ^ T, go to CIPHER.
- CIPHER:
  - o_core_enable = 1, o_core_decrypt = latched direction, o_core_key = key1.
  - On i_core_valid: o_blk ← i_core_data ^ T, o_blk_valid ← 1, o_core_enable ← 0, go to EMIT.
- EMIT:
  - Hold o_blk and o_blk_valid until i_blk_ready.
  - On that handshake: o_blk_valid ← 0 and T ← {T[126:0],1'b0} ^ (T[127] ? 128'h87 : 0).
  - If counter == BLOCKS_PER_SECTOR−1, go to DONE; otherwise counter+1 and go to GET_BLK.
- DONE: o_sector_done = 1 for exactly one cycle, then IDLE.
- o_core_enable is always low for at least one cycle between two core operations (GET_BLK/EMIT guarantee this). The core must therefore never see back-to-back requests merged.
- Minimum per-block latency is 1 (GET_BLK) + core latency + 1 (EMIT). The input and output streams never overlap: o_blk_ready = 0 while o_blk_valid = 1.
- Abort: if i_key_valid = 0 in any non-IDLE state, the next state is IDLE.
  - o_core_enable, o_blk_valid and o_blk_ready go to 0 at that edge; o_abort pulses for one cycle.
  - o_sector_done is not asserted; any partially processed block is discarded.
  - A core result arriving after the abort is ignored.
- Asynchronous reset mid-operation: immediate return to the reset values. No done or abort pulse is produced.
- i_key, i_sector and i_decrypt may change after being latched without affecting the current sector.
- o_blk_valid rises only on the cycle after i_core_valid; o_blk is stable while o_blk_valid = 1 and i_blk_ready = 0.

Test Plan:
Bench core model: result = data ^ key[127:0] after 3 cycles with enable held high.
1. BLOCKS_PER_SECTOR = 2. Start with i_sector = 64'h5, key2[127:0] = 128'hA0, key1[127:0] = 128'h0F.
   - Required: T0 = 128'hA5 and T1 = 128'h14A.
   - Block 0 = 128'h1 → o_blk = 128'h1 ^ A5 ^ 0F ^ A5 = 128'h0E.
   - Block 1 = 128'h0 → o_blk = 128'h0F.
   - o_sector_done pulses once; o_busy ends low.
2. Tweak with T[127] = 1, e.g. T0 = 128'h8000…0001: after one block, T = 128'h0000…0085 (checked through the second block's output).
3. Backpressure: hold i_blk_ready low 10 cycles in EMIT → o_blk stays stable, o_blk_valid stays high, and no new core request is issued.
4. Drop i_key_valid during CIPHER → o_abort pulses once, the state returns to IDLE, and the late i_core_valid is ignored; a subsequent i_start runs cleanly.
5. i_start asserted while busy, and i_start with i_key_valid = 0 → both ignored (o_busy unchanged, no core request).
6. Assert i_rstn low during TWEAK → all outputs 0 immediately; after release, a full 32-block sector completes with exactly 32 output handshakes.
